// File: rtl/acs_pm_unit.sv
// Add-compare-select stage for a K=3, rate-1/2 Viterbi decoder.
// Keeps four path metrics, picks one survivor per next state, normalizes
// the metrics when all of them pass the half-range point, and reports the
// decision bits, traceback write address and the best state with its metric.
module acs_pm_unit #(
  parameter int PM_W     = 8,
  parameter int INIT_PEN = 16,
  parameter int TB_DEPTH = 32,
  localparam int ADDR_W  = $clog2(TB_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              in_valid,
  input  logic [7:0]        bm_a_vec,
  input  logic [7:0]        bm_b_vec,
  output logic              out_valid,
  output logic [3:0]        dec,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        best_state,
  output logic [PM_W-1:0]   best_pm,
  output logic              pm_norm
);

  // Half-range threshold, one bit wider than a path metric so candidates compare cleanly.
  localparam logic [PM_W:0] HALF = {2'b01, {(PM_W-1){1'b0}}};

  // Registered path metrics and the traceback address counter.
  logic [3:0][PM_W-1:0] pm_r;
  logic [ADDR_W-1:0]    addr_r;

  // Combinational add-compare-select results.
  logic [3:0][PM_W:0]   cand_a_s;
  logic [3:0][PM_W:0]   cand_b_s;
  logic [3:0][PM_W:0]   sel_s;
  logic [3:0]           dec_s;
  logic                 norm_s;
  logic [3:0][PM_W-1:0] new_pm_s;
  logic [1:0]           best_state_s;
  logic [PM_W-1:0]      best_pm_s;

  // Add branch metrics to both predecessors and keep the smaller sum; ties keep p_a.
  always_comb begin
    cand_a_s = '0;
    cand_b_s = '0;
    sel_s    = '0;
    dec_s    = 4'b0000;
    for (int ns = 0; ns < 4; ns++) begin
      // p_a = 2*ns[0], p_b = 2*ns[0]+1
      cand_a_s[ns] = {1'b0, pm_r[2*(ns%2)]}     + (PM_W+1)'(bm_a_vec[2*ns +: 2]);
      cand_b_s[ns] = {1'b0, pm_r[2*(ns%2) + 1]} + (PM_W+1)'(bm_b_vec[2*ns +: 2]);
      dec_s[ns]    = (cand_b_s[ns] < cand_a_s[ns]);
      sel_s[ns]    = dec_s[ns] ? cand_b_s[ns] : cand_a_s[ns];
    end
  end

  // Normalize only when every survivor sits at or above the half-range point.
  always_comb begin
    norm_s   = 1'b1;
    new_pm_s = '0;
    for (int ns = 0; ns < 4; ns++) begin
      norm_s = norm_s & (sel_s[ns] >= HALF);
    end
    for (int ns = 0; ns < 4; ns++) begin
      new_pm_s[ns] = PM_W'(sel_s[ns] - (norm_s ? HALF : {(PM_W+1){1'b0}}));
    end
  end

  // Find the lowest-index state holding the minimum new metric.
  always_comb begin
    best_state_s = 2'd0;
    best_pm_s    = new_pm_s[0];
    for (int ns = 1; ns < 4; ns++) begin
      best_state_s = (new_pm_s[ns] < best_pm_s) ? 2'(ns) : best_state_s;
      best_pm_s    = (new_pm_s[ns] < best_pm_s) ? new_pm_s[ns] : best_pm_s;
    end
  end

  // Metric and address state; reset beats init, init drops a coincident step.
  always_ff @(posedge clk) begin
    if (rst) begin
      pm_r   <= {PM_W'(INIT_PEN), PM_W'(INIT_PEN), PM_W'(INIT_PEN), PM_W'(0)};
      addr_r <= '0;
    end else if (init) begin
      pm_r   <= {PM_W'(INIT_PEN), PM_W'(INIT_PEN), PM_W'(INIT_PEN), PM_W'(0)};
      addr_r <= '0;
    end else if (in_valid) begin
      pm_r   <= new_pm_s;
      addr_r <= addr_r + ADDR_W'(1);
    end else begin
      pm_r   <= pm_r;
      addr_r <= addr_r;
    end
  end

  // Step outputs: one-cycle valid pulse, payload holds between steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      dec        <= 4'b0000;
      wr_addr    <= '0;
      best_state <= 2'd0;
      best_pm    <= '0;
      pm_norm    <= 1'b0;
    end else if (init) begin
      out_valid  <= 1'b0;
      pm_norm    <= 1'b0;
    end else if (in_valid) begin
      out_valid  <= 1'b1;
      dec        <= dec_s;
      wr_addr    <= addr_r;
      best_state <= best_state_s;
      best_pm    <= best_pm_s;
      pm_norm    <= norm_s;
    end else begin
      out_valid  <= 1'b0;
      pm_norm    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acs_pm_unit.sv
// Scoreboard bench for acs_pm_unit: directed steps push hand-computed
// results; a monitor pops and compares on every out_valid and checks
// that outputs hold (or show reset values) on every other cycle.
module tb_acs_pm_unit;

  logic       clk;
  logic       rst;
  logic       init;
  logic       in_valid;
  logic [7:0] bm_a_vec;
  logic [7:0] bm_b_vec;
  logic       out_valid;
  logic [3:0] dec;
  logic [4:0] wr_addr;
  logic [1:0] best_state;
  logic [7:0] best_pm;
  logic       pm_norm;

  typedef struct packed {
    logic [3:0] dec;
    logic [4:0] wr;
    logic [1:0] bs;
    logic [7:0] bpm;
    logic       norm;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_err = 0;

  acs_pm_unit #(.PM_W(8), .INIT_PEN(16), .TB_DEPTH(32)) dut (
    .clk(clk), .rst(rst), .init(init), .in_valid(in_valid),
    .bm_a_vec(bm_a_vec), .bm_b_vec(bm_b_vec),
    .out_valid(out_valid), .dec(dec), .wr_addr(wr_addr),
    .best_state(best_state), .best_pm(best_pm), .pm_norm(pm_norm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Apply one cycle of inputs, changed just after the rising edge.
  task automatic drive(input logic r, input logic i, input logic v,
                       input logic [7:0] a, input logic [7:0] b);
    @(posedge clk);
    #1;
    rst = r; init = i; in_valid = v; bm_a_vec = a; bm_b_vec = b;
  endtask

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [3:0] e_dec,
                      input logic [4:0] e_wr, input logic [1:0] e_bs, input logic [7:0] e_bpm,
                      input logic e_norm);
    exp_t e;
    drive(1'b0, 1'b0, 1'b1, a, b);
    e.dec = e_dec; e.wr = e_wr; e.bs = e_bs; e.bpm = e_bpm; e.norm = e_norm;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Monitor: reset values after a reset edge, scoreboard pop on valid, hold otherwise.
  initial begin
    logic r_seen;
    logic active;
    exp_t e;
    active = 1'b0;
    last_exp = '0;
    forever begin
      @(posedge clk);
      r_seen = rst;
      @(negedge clk);
      if (r_seen) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dec", 32'(dec), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_best_state", 32'(best_state), 32'd0);
        chk("rst_best_pm", 32'(best_pm), 32'd0);
        chk("rst_pm_norm", 32'(pm_norm), 32'd0);
        last_exp = '0;
        active = 1'b1;
      end else if (active) begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", 32'(out_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("dec", 32'(dec), 32'(e.dec));
            chk("wr_addr", 32'(wr_addr), 32'(e.wr));
            chk("best_state", 32'(best_state), 32'(e.bs));
            chk("best_pm", 32'(best_pm), 32'(e.bpm));
            chk("pm_norm", 32'(pm_norm), 32'(e.norm));
            last_exp = e;
          end
        end else begin
          chk("hold_dec", 32'(dec), 32'(last_exp.dec));
          chk("hold_wr_addr", 32'(wr_addr), 32'(last_exp.wr));
          chk("hold_best_state", 32'(best_state), 32'(last_exp.bs));
          chk("hold_best_pm", 32'(best_pm), 32'(last_exp.bpm));
          chk("idle_pm_norm", 32'(pm_norm), 32'd0);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; init = 1'b0; in_valid = 1'b0; bm_a_vec = 8'h00; bm_b_vec = 8'h00;
    // Reset, then bm_a=0 / bm_b=2 everywhere -> PM {0,16,0,16}
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    step(8'h00, 8'hAA, 4'b0000, 5'd0, 2'd0, 8'd0, 1'b0);
    idle(1);

    // Tie case, then steps that drive distinct decisions and best_state=1
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    step(8'h00, 8'h00, 4'b0000, 5'd0, 2'd0, 8'd0, 1'b0);   // PM {0,16,0,16}
    idle(2);
    step(8'h00, 8'h00, 4'b0000, 5'd1, 2'd0, 8'd0, 1'b0);   // PM {0,0,0,0}
    step(8'h93, 8'h16, 4'b1001, 5'd2, 2'd1, 8'd0, 1'b0);   // PM {2,0,1,0}
    step(8'h00, 8'h00, 4'b1111, 5'd3, 2'd0, 8'd0, 1'b0);   // PM {0,0,0,0}
    step(8'h55, 8'hFF, 4'b0000, 5'd4, 2'd0, 8'd1, 1'b0);   // PM {1,1,1,1}
    idle(1);

    // Normalization: 64 back-to-back steps of bm=2; metrics reach 128 on step 64
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    for (int k = 1; k <= 64; k++) begin
      step(8'hAA, 8'hAA, 4'b0000, 5'((k - 1) % 32), 2'd0,
           (k == 64) ? 8'd0 : 8'(2 * k), (k == 64) ? 1'b1 : 1'b0);
    end
    idle(2);

    // Address wrap with gaps between steps
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    for (int k = 1; k <= 33; k++) begin
      step(8'h00, 8'h00, 4'b0000, 5'((k - 1) % 32), 2'd0, 8'd0, 1'b0);
      idle(1 + (k % 2));
    end

    // init with in_valid: step dropped, PMs back to {0,16,16,16}
    drive(1'b0, 1'b1, 1'b1, 8'hFF, 8'h00);
    step(8'hFF, 8'h00, 4'b1010, 5'd0, 2'd0, 8'd3, 1'b0);   // PM {3,16,3,16}
    idle(1);

    // Reset mid-stream with a step in flight
    step(8'h00, 8'h00, 4'b0000, 5'd1, 2'd0, 8'd3, 1'b0);   // PM {3,3,3,3}
    drive(1'b1, 1'b0, 1'b1, 8'hFF, 8'h00);
    idle(2);
    step(8'h00, 8'h00, 4'b0000, 5'd0, 2'd0, 8'd0, 1'b0);
    idle(3);

    chk("queue_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
